// File: rtl/au_sched_pkg.sv
// au_sched_pkg: shared types and defaults for the arithmetic-unit scheduler
package au_sched_pkg;
  typedef enum logic {RUN, DRAIN} state_t;
  localparam logic MODE_INT8 = 1'b0;
  localparam logic MODE_INT4 = 1'b1;
  localparam int AU_LAT_DEF = 4;
  localparam int MAX_RUN_DEF = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, ptr names the highest-priority requester
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);
  logic [N-1:0] rot, first;
  assign rot = N'({req, req} >> ptr);
  assign first = rot & (~rot + N'(1));
  assign gnt = N'(({first, first} << ptr) >> N);
endmodule

// File: rtl/au_scheduler.sv
// au_scheduler: mode-batched round-robin issue into a fixed-latency arithmetic unit
module au_scheduler
  import au_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AU_LAT = AU_LAT_DEF,
  parameter int MAX_RUN = MAX_RUN_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [16*N_REQ-1:0]      req_x,
  input  logic [8*N_REQ-1:0]       req_y,
  input  logic [N_REQ-1:0]         req_mode,
  output logic [15:0]              au_x,
  output logic [7:0]               au_y,
  output logic                     au_mode,
  input  logic [31:0]              au_p,
  output logic                     res_valid,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [31:0]              res_p
);
  localparam int W = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_RUN + 1);
  state_t state, state_n;
  logic cur_mode, hs, drain, idle;
  logic [CW-1:0] run_cnt;
  logic [W-1:0] ptr, sel;
  logic [N_REQ-1:0] elig, other, arb_req, gnt;
  logic [15:0] x_sel;
  logic [7:0] y_sel;
  logic [AU_LAT:0] trk_v;
  logic [W-1:0] trk_id [AU_LAT+1];
  assign elig = req_valid & ~(req_mode ^ {N_REQ{cur_mode}});
  assign other = req_valid & (req_mode ^ {N_REQ{cur_mode}});
  assign drain = |other & (~|elig | run_cnt == CW'(MAX_RUN));
  // Mode may only flip once every issued op has left the result register too
  assign idle = ~|trk_v & ~res_valid;
  assign arb_req = state == RUN ? elig : req_valid;
  assign hs = state == RUN & ~drain & |gnt & ~reset;
  assign req_ready = hs ? gnt : '0;
  assign au_mode = cur_mode;
  rr_arbiter #(.N(N_REQ)) u_arb (.req(arb_req), .ptr(ptr), .gnt(gnt));
  always_comb begin
    sel = '0;
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) begin
        sel = W'(i);
        x_sel = req_x[16*i +: 16];
        y_sel = req_y[8*i +: 8];
      end
  end
  always_comb begin
    state_n = state;
    state_n = state == RUN ? (drain ? DRAIN : RUN) : (idle ? RUN : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cur_mode <= MODE_INT8;
      run_cnt <= '0;
      ptr <= '0;
      trk_v <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_p <= '0;
      au_x <= '0;
      au_y <= '0;
    end else begin
      state <= state_n;
      trk_v <= {trk_v[AU_LAT-1:0], hs};
      res_valid <= trk_v[AU_LAT];
      if (trk_v[AU_LAT]) begin
        res_id <= trk_id[AU_LAT];
        res_p <= au_p;
      end
      if (hs) begin
        au_x <= x_sel;
        au_y <= y_sel;
        ptr <= sel == W'(N_REQ - 1) ? '0 : sel + W'(1);
        run_cnt <= run_cnt == CW'(MAX_RUN) ? run_cnt : run_cnt + CW'(1);
      end
      if (state == DRAIN && idle) begin
        run_cnt <= '0;
        if (|gnt) cur_mode <= |(gnt & req_mode);
      end
    end
  end
  always_ff @(posedge clk) begin
    trk_id[0] <= sel;
    for (int i = 1; i <= AU_LAT; i++) trk_id[i] <= trk_id[i-1];
  end
endmodule

// File: tb/tb_au_scheduler.sv
// tb_au_scheduler: directed checks of au_scheduler with a 4-cycle external arithmetic unit
module tb_au_scheduler;
  localparam int N = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_mode = '0;
  logic [16*N-1:0] req_x = '0;
  logic [8*N-1:0] req_y = '0;
  logic [15:0] au_x;
  logic [7:0] au_y;
  logic au_mode, res_valid;
  logic [31:0] au_p, res_p;
  logic [1:0] res_id;
  int n_chk = 0, n_fail = 0, cyc = 0, n_res = 0;
  logic [31:0] pipe [4];
  logic [31:0] last_p = '0;
  typedef struct { logic [1:0] id; int t; logic [31:0] p; } exp_t;
  exp_t q[$];

  au_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_mode(req_mode), .au_x(au_x), .au_y(au_y),
    .au_mode(au_mode), .au_p(au_p), .res_valid(res_valid), .res_id(res_id), .res_p(res_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mul(logic [15:0] x, logic [7:0] y, logic m);
    logic [31:0] p;
    p = '0;
    if (!m) begin
      p[15:0] = 16'($signed(x[7:0]) * $signed(y));
      p[31:16] = 16'($signed(x[15:8]) * $signed(y));
    end else
      for (int k = 0; k < 4; k++) p[8*k +: 8] = 8'($signed(x[4*k +: 4]) * $signed(y[2:0]));
    return p;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mul(au_x, au_y, au_mode);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    pipe[3] <= pipe[2];
  end
  assign au_p = pipe[3];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      last_p = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i])
          q.push_back('{2'(i), cyc, mul(req_x[16*i +: 16], req_y[8*i +: 8], req_mode[i])});
      if (req_ready != '0) check("ready_onehot", 32'($countones(req_ready)), 1);
      if (res_valid) begin
        if (q.size() == 0) check("res_unexpected", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("res_id", 32'(res_id), 32'(e.id));
          check("res_p", res_p, e.p);
          check("res_lat", 32'(cyc - e.t), 6);
          n_res++;
        end
        last_p = res_p;
      end else check("res_p_hold", res_p, last_p);
    end
  end

  initial begin
    int k, n0, nb;
    bit done;
    req_valid = '1;
    step();
    step();
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_res_p", res_p, 0);
    check("rst_au_x", 32'(au_x), 0);
    check("rst_au_y", 32'(au_y), 0);
    check("rst_au_mode", 32'(au_mode), 0);
    step();
    reset = 1'b0;
    req_valid = '0;

    step();
    req_x[15:0] = 16'h0203;
    req_y[7:0] = 8'h04;
    req_mode = '0;
    req_valid = 4'b0001;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    k = 1;
    while (!res_valid && k < 20) begin
      step();
      k++;
    end
    check("single_lat", 32'(k), 6);
    check("single_id", 32'(res_id), 0);
    check("single_p", res_p, 32'h0008000C);

    do_reset();
    for (int i = 0; i < N; i++) begin
      req_x[16*i +: 16] = 16'h1357 + 16'(i * 16'h0921);
      req_y[8*i +: 8] = 8'(8'hF3 + i * 5);
    end
    nb = n_res;
    req_valid = 4'b1111;
    for (int j = 0; j < 12; j++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(1) << (j % 4));
      step();
    end
    req_valid = '0;
    repeat (8) step();
    check("rr_results", 32'(n_res - nb), 12);

    do_reset();
    req_x[31:0] = {16'h7F3A, 16'h0102};
    req_y[15:0] = {8'h05, 8'h03};
    req_mode = 4'b0010;
    req_valid = 4'b0011;
    #1;
    check("sw_first", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0010;
    for (int j = 1; j <= 7; j++) begin
      #1;
      check("sw_drain_ready", 32'(req_ready), 0);
      check("sw_drain_mode", 32'(au_mode), 0);
      if (j == 4) check("au_x_hold", 32'(au_x), 32'h0102);
      step();
    end
    #1;
    check("sw_mode", 32'(au_mode), 1);
    check("sw_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    repeat (8) step();

    do_reset();
    req_mode = 4'b0100;
    req_x[47:0] = {16'hA5C3, 16'h0F7E, 16'h8001};
    req_y[23:0] = {8'h06, 8'h81, 8'h7F};
    req_valid = 4'b0111;
    n0 = 0;
    done = 1'b0;
    for (int j = 0; j < 80 && !done; j++) begin
      #1;
      if (req_ready[2]) done = 1'b1;
      else begin
        if (|req_ready[1:0]) n0++;
        step();
      end
    end
    check("starve_done", 32'(done), 1);
    check("starve_cnt", 32'(n0), 16);
    check("starve_mode", 32'(au_mode), 1);
    step();
    req_valid = '0;
    repeat (10) step();

    req_mode = 4'b0111;
    req_valid = 4'b0111;
    repeat (3) step();
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("rst_mid_res_valid", 32'(res_valid), 0);
      step();
    end
    check("rst_mid_au_mode", 32'(au_mode), 0);
    req_mode = '0;
    req_valid = 4'b1010;
    #1;
    check("rst_mid_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    repeat (10) step();
    check("sb_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
